srl_update_ctrl: RTL and testbench
==================================

// Module: srl_update_ctrl
// PURPOSE
//  Sequencer for SRL-based TCAM entry updates. It accepts one update request per transaction on a
//  valid/ready port and targets either one SRL block or all blocks (broadcast).
//  It drives per-block shift enables for SRL_DEPTH cycles, with a shift index the data path uses to build each shifted bit.
//  It then issues a one-cycle commit write-enable. Sits between the host update port and the SRL array / entry-valid logic.
// PARAMETERS
//  NUM_BLOCKS  8   number of SRL blocks (ce width); any value >=1, need not be a power of two
//  SRL_DEPTH   32  shift cycles per update (SRL length); >=2
//  SEL_W       $clog2(NUM_BLOCKS) (min 1)  block-select width, derived, not overridden
//  IDX_W       $clog2(SRL_DEPTH)           shift-index width, derived, not overridden
// PORTS
//  clk          in   1           single clock, all state on rising edge
//  rst_n        in   1           asynchronous active-low reset
//  req_valid    in   1           update request valid
//  req_ready    out  1           controller can accept request
//  req_sel      in   SEL_W       target block index
//  req_bcast    in   1           1 = update all blocks, req_sel ignored
//  abort        in   1           cancel an in-flight update (no commit)
//  ce           out  NUM_BLOCKS  per-block SRL shift enable
//  shift_idx    out  IDX_W       SRL address of the bit being shifted this cycle
//  we_block     out  1           one-cycle commit write-enable
//  we_sel       out  NUM_BLOCKS  one-hot (or all-ones if bcast) block mask qualifying we_block
//  busy         out  1           high in SHIFT or COMMIT
//  req_err      out  1           one-cycle pulse: request rejected (req_sel >= NUM_BLOCKS, not bcast)
// BEHAVIOUR
//  Reset (rst_n low, async): state=IDLE, counter=0, ce=0, shift_idx=0, we_block=0, we_sel=0, busy=0,
//   req_err=0, req_ready=0. req_ready rises on the first clock edge after rst_n deasserts.
//  States: IDLE -> SHIFT -> COMMIT -> IDLE; all outputs registered.
//  IDLE: req_ready=1. Accept on req_valid&req_ready at edge T.
//   If req_bcast=0 and req_sel>=NUM_BLOCKS: no transfer, stay IDLE, req_err=1 during T+1.
//   Otherwise: latch mask (bcast ? all ones : onehot(req_sel)), counter=SRL_DEPTH-1, go SHIFT.
//  SHIFT: occupies cycles T+1..T+SRL_DEPTH. ce=mask, shift_idx=counter, counting down SRL_DEPTH-1..0.
//   req_ready=0. Leave for COMMIT after the cycle in which counter==0.
//  COMMIT: cycle T+SRL_DEPTH+1. ce=0, we_block=1, we_sel=mask. Go to IDLE; req_ready=1 at T+SRL_DEPTH+2.
//   Back-to-back requests are therefore accepted every SRL_DEPTH+2 cycles.
//  abort:
//   - Sampled high in SHIFT: next cycle IDLE, ce=0, no we_block.
//   - Sampled high in COMMIT: ignored; the commit completes.
//   - Sampled high in IDLE: blocks acceptance that cycle.
//   - abort and req_valid high together in IDLE: abort wins, nothing accepted, no req_err.
//  ce and we_block are never high in the same cycle. ce is 0 outside SHIFT. we_sel is 0 when we_block=0.
//  Counter wrap: never decrements below 0, never wraps.
//   For non-power-of-2 SRL_DEPTH, shift_idx never exceeds SRL_DEPTH-1.
//  Reset mid-operation: outputs clear immediately (async); the partial shift is discarded and no commit is issued.
// STRUCTURE
//  Shared package tcam_pkg: state encodings ST_IDLE/ST_SHIFT/ST_COMMIT and a clog2 helper with min-1 clamp.
//  Sub-module blk_sel_dec (SEL_W -> NUM_BLOCKS one-hot with out-of-range flag, combinational, bcast override)
//   feeds the mask register. FSM and counter stay in this module.
// TESTING
//  1 NUM_BLOCKS=8, SRL_DEPTH=32: req_sel=3, bcast=0 at T -> ce=8'h08 for T+1..T+32,
//    shift_idx 31..0, we_block=1 and we_sel=8'h08 at T+33, req_ready=1 at T+34.
//  2 bcast=1, req_sel=X -> ce=8'hFF for 32 cycles, then we_sel=8'hFF with we_block.
//  3 NUM_BLOCKS=6, req_sel=7 -> req_err pulse one cycle, req_ready stays 1, ce and we_block stay 0.
//  4 Abort high at the 10th SHIFT cycle -> ce=0 next cycle, state IDLE, no we_block;
//    abort during COMMIT -> we_block still pulses.
//  5 rst_n low at the 5th SHIFT cycle -> outputs 0 asynchronously;
//    after release, a new request at sel=0 completes normally with a full 32-cycle shift.
//  6 req_valid held high for 3 requests -> accepts spaced exactly 34 cycles apart, counts monotonic, no overlap of ce/we_block.

Source files
------------

// File: rtl/tcam_pkg.sv
// Shared definitions for the TCAM update path: controller state encoding and
// a clog2 helper that never returns less than 1 (so 1-entry widths stay legal).
package tcam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/srl_update_ctrl_blk_sel_dec.sv
// Block-select decoder: turns a block index into a one-hot block mask,
// flags indices beyond the last block, and forces all-ones on broadcast.
module blk_sel_dec #(
  parameter int NUM_BLOCKS = 8,
  parameter int SEL_W      = 3
) (
  input  logic [SEL_W-1:0]      sel_i,
  input  logic                  bcast_i,
  output logic [NUM_BLOCKS-1:0] mask_o,
  output logic                  oor_o
);

  // Decode index to mask; an out-of-range index yields an empty mask.
  always_comb begin
    mask_o = '0;
    oor_o  = 1'b0;
    if (bcast_i) begin
      mask_o = '1;
    end else begin
      oor_o = (32'(sel_i) >= 32'(NUM_BLOCKS));
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        mask_o[i] = (32'(sel_i) == 32'(i));
      end
    end
  end

endmodule

// File: rtl/srl_update_ctrl.sv
// SRL update sequencer: accepts one update request, drives the target block
// shift enables for SRL_DEPTH cycles with a descending shift index, then
// issues a single-cycle commit. Every output comes straight from a register.
module srl_update_ctrl
  import tcam_pkg::*;
#(
  parameter int  NUM_BLOCKS = 8,
  parameter int  SRL_DEPTH  = 32,
  localparam int SEL_W      = clog2_min1(NUM_BLOCKS),
  localparam int IDX_W      = clog2_min1(SRL_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [SEL_W-1:0]      req_sel,
  input  logic                  req_bcast,
  input  logic                  abort,
  output logic [NUM_BLOCKS-1:0] ce,
  output logic [IDX_W-1:0]      shift_idx,
  output logic                  we_block,
  output logic [NUM_BLOCKS-1:0] we_sel,
  output logic                  busy,
  output logic                  req_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SRL_DEPTH - 1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic [NUM_BLOCKS-1:0]   mask_q, mask_d;
  logic [NUM_BLOCKS-1:0]   ce_q, ce_d;
  logic [NUM_BLOCKS-1:0]   we_sel_q, we_sel_d;
  logic                    we_q, we_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;
  logic                    rdy_q, rdy_d;
  logic [NUM_BLOCKS-1:0]   dec_mask;
  logic                    dec_oor;

  blk_sel_dec #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .SEL_W      (SEL_W)
  ) u_dec (
    .sel_i   (req_sel),
    .bcast_i (req_bcast),
    .mask_o  (dec_mask),
    .oor_o   (dec_oor)
  );

  // Next-state and next-output logic; outputs are precomputed for the coming
  // cycle so they can be registered. The counter doubles as shift_idx and
  // therefore rests at zero outside SHIFT.
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    mask_d   = mask_q;
    ce_d     = '0;
    we_d     = 1'b0;
    we_sel_d = '0;
    err_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && rdy_q && !abort) begin
          if (dec_oor) begin
            err_d = 1'b1;
          end else begin
            mask_d  = dec_mask;
            cnt_d   = LAST_IDX;
            ce_d    = dec_mask;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d  = ST_COMMIT;
          we_d     = 1'b1;
          we_sel_d = mask_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
          ce_d  = mask_q;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    rdy_d  = (state_d == ST_IDLE);
  end

  // State and output registers; reset discards any partial update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mask_q   <= '0;
      ce_q     <= '0;
      we_q     <= 1'b0;
      we_sel_q <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      ce_q     <= ce_d;
      we_q     <= we_d;
      we_sel_q <= we_sel_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      rdy_q    <= rdy_d;
    end
  end

  assign req_ready = rdy_q;
  assign ce        = ce_q;
  assign shift_idx = cnt_q;
  assign we_block  = we_q;
  assign we_sel    = we_sel_q;
  assign busy      = busy_q;
  assign req_err   = err_q;

endmodule

// File: tb/tb_srl_update_ctrl.sv
// Bench for srl_update_ctrl: an 8-block and a 6-block instance (both 32 deep)
// run side by side against a transaction-level reference model.
module tb_srl_update_ctrl;

  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic       valid_i [2];
  logic       bcast_i [2];
  logic       abort_i [2];
  logic [2:0] sel_i   [2];

  logic       rdy8, we8, busy8, err8;
  logic [7:0] ce8, wsel8;
  logic [4:0] idx8;
  logic       rdy6, we6, busy6, err6;
  logic [5:0] ce6, wsel6;
  logic [4:0] idx6;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model: an active transaction is described only by how many
  // clock edges have passed since it was accepted (k) and its block mask.
  bit          act_m  [2];
  bit          rdy_m  [2];
  bit          err_m  [2];
  int          k_m    [2];
  logic [31:0] mask_m [2];
  int          nb_of  [2] = '{8, 6};

  srl_update_ctrl #(.NUM_BLOCKS(8), .SRL_DEPTH(DEPTH)) u8 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid_i[0]), .req_ready(rdy8),
    .req_sel(sel_i[0]), .req_bcast(bcast_i[0]), .abort(abort_i[0]),
    .ce(ce8), .shift_idx(idx8), .we_block(we8), .we_sel(wsel8),
    .busy(busy8), .req_err(err8)
  );

  srl_update_ctrl #(.NUM_BLOCKS(6), .SRL_DEPTH(DEPTH)) u6 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid_i[1]), .req_ready(rdy6),
    .req_sel(sel_i[1]), .req_bcast(bcast_i[1]), .abort(abort_i[1]),
    .ce(ce6), .shift_idx(idx6), .we_block(we6), .we_sel(wsel6),
    .busy(busy6), .req_err(err6)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      act_m[d] = 1'b0;
      rdy_m[d] = 1'b0;
      err_m[d] = 1'b0;
      k_m[d]   = 0;
    end
  endtask

  task automatic model_edge(input int d);
    err_m[d] = 1'b0;
    if (!rst_n) begin
      act_m[d] = 1'b0;
      rdy_m[d] = 1'b0;
      return;
    end
    if (act_m[d]) begin
      if (k_m[d] == DEPTH + 1) act_m[d] = 1'b0;
      else if (abort_i[d]) act_m[d] = 1'b0;
      else k_m[d]++;
    end else if (rdy_m[d] && valid_i[d] && !abort_i[d]) begin
      if (!bcast_i[d] && int'(sel_i[d]) >= nb_of[d]) begin
        err_m[d] = 1'b1;
      end else begin
        act_m[d]  = 1'b1;
        k_m[d]    = 1;
        mask_m[d] = bcast_i[d] ? ((32'd1 << nb_of[d]) - 32'd1) : (32'd1 << sel_i[d]);
      end
    end
    rdy_m[d] = !act_m[d];
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      logic [31:0] ce_o, ws_o, idx_o;
      logic        rd_o, we_o, bs_o, er_o;
      bit          shifting, committing;
      if (d == 0) begin
        ce_o = 32'(ce8); ws_o = 32'(wsel8); idx_o = 32'(idx8);
        rd_o = rdy8; we_o = we8; bs_o = busy8; er_o = err8;
      end else begin
        ce_o = 32'(ce6); ws_o = 32'(wsel6); idx_o = 32'(idx6);
        rd_o = rdy6; we_o = we6; bs_o = busy6; er_o = err6;
      end
      shifting   = act_m[d] && (k_m[d] <= DEPTH);
      committing = act_m[d] && (k_m[d] == DEPTH + 1);
      check($sformatf("ce[%0d]", d), ce_o, shifting ? mask_m[d] : 32'd0);
      check($sformatf("shift_idx[%0d]", d), idx_o, shifting ? 32'(DEPTH - k_m[d]) : 32'd0);
      check($sformatf("we_block[%0d]", d), 32'(we_o), 32'(committing));
      check($sformatf("we_sel[%0d]", d), ws_o, committing ? mask_m[d] : 32'd0);
      check($sformatf("busy[%0d]", d), 32'(bs_o), 32'(act_m[d]));
      check($sformatf("req_ready[%0d]", d), 32'(rd_o), 32'(rdy_m[d]));
      check($sformatf("req_err[%0d]", d), 32'(er_o), 32'(err_m[d]));
      check($sformatf("ce_we_overlap[%0d]", d), 32'((ce_o != 0) && we_o), 32'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_ready(input int d);
    int n;
    n = 0;
    while ((((d == 0) ? rdy8 : rdy6) !== 1'b1) && (n < 100)) begin
      tick();
      n++;
    end
    if (n >= 100) check("wait_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input int d, input int sel, input bit bc);
    wait_ready(d);
    valid_i[d] = 1'b1;
    sel_i[d]   = 3'(sel);
    bcast_i[d] = bc;
    tick();
    valid_i[d] = 1'b0;
    bcast_i[d] = 1'b0;
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    run(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int acc_cyc [$];
    logic [7:0] prev_ce;
    for (int d = 0; d < 2; d++) begin
      valid_i[d] = 1'b0; bcast_i[d] = 1'b0; abort_i[d] = 1'b0; sel_i[d] = 3'd0;
    end
    model_reset();
    #2;
    check_all();
    run(2);
    rst_n = 1'b1;
    run(2);

    // single-block and broadcast updates on both instances
    send(0, 3, 1'b0);
    send(1, 5, 1'b0);
    run(36);
    send(0, 6, 1'b1);
    send(1, 0, 1'b1);
    run(36);

    // out-of-range selects on the 6-block instance, then abort+valid together
    send(1, 7, 1'b0);
    run(2);
    send(1, 6, 1'b0);
    run(2);
    wait_ready(0);
    valid_i[0] = 1'b1; sel_i[0] = 3'd1; abort_i[0] = 1'b1;
    tick();
    valid_i[0] = 1'b0; abort_i[0] = 1'b0;
    run(2);

    // abort in the 10th shift cycle, then abort during commit
    send(0, 2, 1'b0);
    run(9);
    abort_i[0] = 1'b1;
    tick();
    abort_i[0] = 1'b0;
    run(3);
    send(0, 4, 1'b0);
    run(32);
    abort_i[0] = 1'b1;
    tick();
    abort_i[0] = 1'b0;
    run(3);

    // reset in the 5th shift cycle, then a full update on block 0
    send(0, 7, 1'b0);
    run(4);
    async_reset();
    send(0, 0, 1'b0);
    run(36);

    // valid held high: three accepts spaced DEPTH+2 cycles apart
    wait_ready(0);
    valid_i[0] = 1'b1; sel_i[0] = 3'd5;
    prev_ce = ce8;
    for (int n = 0; n < 200 && acc_cyc.size() < 3; n++) begin
      tick();
      if (ce8 != 8'd0 && prev_ce == 8'd0) acc_cyc.push_back(cyc);
      prev_ce = ce8;
    end
    valid_i[0] = 1'b0;
    check("b2b_accepts", 32'(acc_cyc.size()), 32'd3);
    if (acc_cyc.size() == 3) begin
      check("b2b_spacing_1", 32'(acc_cyc[1] - acc_cyc[0]), 32'(DEPTH + 2));
      check("b2b_spacing_2", 32'(acc_cyc[2] - acc_cyc[1]), 32'(DEPTH + 2));
    end
    run(36);

    // randomized traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      for (int d = 0; d < 2; d++) begin
        valid_i[d] = 1'($urandom_range(0, 1));
        sel_i[d]   = 3'($urandom_range(0, 7));
        bcast_i[d] = ($urandom_range(0, 4) == 0);
        abort_i[d] = ($urandom_range(0, 49) == 0);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
